// File: rtl/tlc_pkg.sv
// Package for the timed traffic light controller.
// Purpose: state codes (ST_MG..ST_MADV) and lamp-vector encoding shared by
// tlc_timed_param and its bench-visible STATE output.
// Ports: none (package).
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_MG    = 3'd0,
    ST_MY    = 3'd1,
    ST_AR_MS = 3'd2,
    ST_SG    = 3'd3,
    ST_SY    = 3'd4,
    ST_AR_SM = 3'd5,
    ST_MADV  = 3'd6,
    ST_BAD   = 3'd7
  } state_t;

  typedef struct packed {
    logic mr;
    logic my;
    logic mg;
    logic ma;
    logic sr;
    logic sy;
    logic sg;
  } lamps_t;

  // Exactly one main colour and one side colour per state; the unused code
  // shows all-red so a corrupted state never lights a conflicting green.
  function automatic lamps_t lamp_decode(input state_t s);
    lamps_t l;
    l = '0;
    case (s)
      ST_MG:   begin l.mg = 1'b1; l.sr = 1'b1; end
      ST_MY:   begin l.my = 1'b1; l.sr = 1'b1; end
      ST_SG:   begin l.mr = 1'b1; l.sg = 1'b1; end
      ST_SY:   begin l.mr = 1'b1; l.sy = 1'b1; end
      ST_MADV: begin l.mr = 1'b1; l.ma = 1'b1; l.sr = 1'b1; end
      default: begin l.mr = 1'b1; l.sr = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase timer for the traffic light controller.
// Purpose: loadable down-counter that advances only on the timebase tick and
// holds at zero.
// Ports: clk (posedge clock), rst_n (sync active-low reset, loads RST_VAL),
//        load/load_val (synchronous load, wins over decrement), tick (timebase
//        strobe), zero (count is zero).
module tlc_phase_timer #(
  parameter int          TW      = 8,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic          zero
);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/tlc_timed_param.sv
// Parametrised main/side intersection controller.
// Purpose: tick-timed phases, latched side/turn demand, actuated side-green
// extension and a protected main advance-arrow phase.
// Ports: CLK, CLR_N (sync active-low reset), TICK (timebase strobe), SD (side
//        detect), MT (main turn demand); lamp outputs MR MY MG MA SR SY SG;
//        STATE (3-bit state code).
// Optional feature: define TLC_PED_EN to add PB input, WALK/DONTWALK outputs
// and parameter WALK_T (pedestrian phase served during side green).
module tlc_timed_param
  import tlc_pkg::*;
#(
  parameter int TW      = 8,
  parameter int MIN_MG  = 8,
  parameter int YEL_T   = 3,
  parameter int AR_T    = 1,
  parameter int SG_T    = 5,
  parameter int EXT_T   = 2,
  parameter int MAX_EXT = 3,
  parameter int ADV_T   = 4
`ifdef TLC_PED_EN
  ,
  parameter int WALK_T  = 6
`endif
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       TICK,
  input  logic       SD,
  input  logic       MT,
`ifdef TLC_PED_EN
  input  logic       PB,
  output logic       WALK,
  output logic       DONTWALK,
`endif
  output logic       MR,
  output logic       MY,
  output logic       MG,
  output logic       MA,
  output logic       SR,
  output logic       SY,
  output logic       SG,
  output logic [2:0] STATE
);

  localparam logic [TW-1:0] LD_MG   = TW'(MIN_MG - 1);
  localparam logic [TW-1:0] LD_YEL  = TW'(YEL_T - 1);
  localparam logic [TW-1:0] LD_AR   = TW'(AR_T - 1);
  localparam logic [TW-1:0] LD_SG   = TW'(SG_T - 1);
  localparam logic [TW-1:0] LD_EXT  = TW'(EXT_T - 1);
  localparam logic [TW-1:0] LD_ADV  = TW'(ADV_T - 1);
  localparam logic [TW-1:0] EXT_MAX = TW'(MAX_EXT);
`ifdef TLC_PED_EN
  localparam logic [TW-1:0] LD_SG_WALK = TW'(((SG_T > WALK_T) ? SG_T : WALK_T) - 1);
`endif

  state_t        state, state_nxt;
  logic          tmr_zero, tmr_load, fire, entering, ext_inc;
  logic [TW-1:0] tmr_val, ext_cnt;
  logic          sd_lat, mt_lat, side_dem, turn_dem;
  lamps_t        lamps;

  assign fire     = TICK & tmr_zero;
  assign entering = (state_nxt != state);
  assign turn_dem = MT | mt_lat;

`ifdef TLC_PED_EN
  logic ped_lat, walk_act, ped_dem;
  assign ped_dem  = PB | ped_lat;
  assign side_dem = SD | sd_lat | ped_dem;
`else
  assign side_dem = SD | sd_lat;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (!CLR_N) state <= ST_AR_SM;
    else        state <= state_nxt;
  end

  // Next-state logic; an SG expiry with live detect re-arms the timer instead
  // of leaving the state.
  always_comb begin
    state_nxt = state;
    ext_inc   = 1'b0;
    case (state)
      ST_MG:    if (fire && (side_dem || turn_dem)) state_nxt = ST_MY;
      ST_MY:    if (fire) state_nxt = ST_AR_MS;
      ST_AR_MS: if (fire) state_nxt = ST_SG;
      ST_SG: begin
        if (fire) begin
          if (SD && (ext_cnt < EXT_MAX)) ext_inc   = 1'b1;
          else                           state_nxt = ST_SY;
        end
      end
      ST_SY:    if (fire) state_nxt = ST_AR_SM;
      ST_AR_SM: if (fire) state_nxt = turn_dem ? ST_MADV : ST_MG;
      ST_MADV:  if (fire) state_nxt = ST_MG;
      default:  state_nxt = ST_AR_SM;
    endcase
  end

  // Timer reload: duration of the state being entered, or one extension.
  always_comb begin
    tmr_load = entering | ext_inc;
    tmr_val  = LD_AR;
    if (ext_inc) begin
      tmr_val = LD_EXT;
    end else begin
      case (state_nxt)
        ST_MG:        tmr_val = LD_MG;
        ST_MY, ST_SY: tmr_val = LD_YEL;
`ifdef TLC_PED_EN
        ST_SG:        tmr_val = ped_dem ? LD_SG_WALK : LD_SG;
`else
        ST_SG:        tmr_val = LD_SG;
`endif
        ST_MADV:      tmr_val = LD_ADV;
        default:      tmr_val = LD_AR;
      endcase
    end
  end

  tlc_phase_timer #(
    .TW      (TW),
    .RST_VAL (LD_AR)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (CLR_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (TICK),
    .zero     (tmr_zero)
  );

  // Demand latches; the clear on entry of the serving state has priority
  // over a request arriving on that same clock.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      sd_lat  <= 1'b0;
      mt_lat  <= 1'b0;
      ext_cnt <= '0;
    end else begin
      if (entering && (state_nxt == ST_SG)) sd_lat <= 1'b0;
      else if (SD && (state != ST_SG))      sd_lat <= 1'b1;

      if (entering && (state_nxt == ST_MADV)) mt_lat <= 1'b0;
      else if (MT && (state != ST_MADV))      mt_lat <= 1'b1;

      if (entering && (state_nxt == ST_SG)) ext_cnt <= '0;
      else if (ext_inc)                     ext_cnt <= ext_cnt + 1'b1;
    end
  end

`ifdef TLC_PED_EN
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      ped_lat  <= 1'b0;
      walk_act <= 1'b0;
    end else begin
      if (entering && (state_nxt == ST_SG)) begin
        walk_act <= ped_dem;
        ped_lat  <= 1'b0;
      end else begin
        if (PB && (state != ST_SG)) ped_lat <= 1'b1;
        if (entering && (state_nxt == ST_SY)) walk_act <= 1'b0;
      end
    end
  end
`endif

  // Output decode from the registered state
  always_comb begin
    lamps = lamp_decode(state);
    MR    = lamps.mr;
    MY    = lamps.my;
    MG    = lamps.mg;
    MA    = lamps.ma;
    SR    = lamps.sr;
    SY    = lamps.sy;
    SG    = lamps.sg;
    STATE = state;
`ifdef TLC_PED_EN
    WALK     = (state == ST_SG) && walk_act;
    DONTWALK = !((state == ST_SG) && walk_act);
`endif
  end

endmodule

// File: tb/tb_tlc_timed_param.sv
module tb_tlc_timed_param;

  localparam int TW      = 8;
  localparam int MIN_MG  = 8;
  localparam int YEL_T   = 3;
  localparam int AR_T    = 1;
  localparam int SG_T    = 5;
  localparam int EXT_T   = 2;
  localparam int MAX_EXT = 3;
  localparam int ADV_T   = 4;

  logic       CLK = 1'b0;
  logic       CLR_N = 1'b0;
  logic       TICK = 1'b0;
  logic       SD = 1'b0;
  logic       MT = 1'b0;
  logic       MR, MY, MG, MA, SR, SY, SG;
  logic [2:0] STATE;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] expq[$];

  tlc_timed_param #(
    .TW(TW), .MIN_MG(MIN_MG), .YEL_T(YEL_T), .AR_T(AR_T), .SG_T(SG_T),
    .EXT_T(EXT_T), .MAX_EXT(MAX_EXT), .ADV_T(ADV_T)
  ) dut (
    .CLK(CLK), .CLR_N(CLR_N), .TICK(TICK), .SD(SD), .MT(MT),
    .MR(MR), .MY(MY), .MG(MG), .MA(MA), .SR(SR), .SY(SY), .SG(SG),
    .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // Phase numbering follows the published state codes.
  function automatic int dur(input int p);
    case (p)
      0: return MIN_MG;
      1: return YEL_T;
      2: return AR_T;
      3: return SG_T;
      4: return YEL_T;
      6: return ADV_T;
      default: return AR_T;
    endcase
  endfunction

  // {MR,MY,MG,MA,SR,SY,SG}
  function automatic logic [6:0] lamps_of(input int p);
    case (p)
      0: return 7'b0010100;
      1: return 7'b0100100;
      3: return 7'b1000001;
      4: return 7'b1000010;
      6: return 7'b1001100;
      default: return 7'b1000100;
    endcase
  endfunction

  // Reference model: phase number plus ticks remaining in that phase.
  int m_ph   = 5;
  int m_left = AR_T;
  int m_ext  = 0;
  bit m_sdl  = 1'b0;
  bit m_mtl  = 1'b0;

  always @(posedge CLK) begin : model
    int nph;
    bit sdem, mdem;
    if (!CLR_N) begin
      m_ph = 5; m_left = AR_T; m_ext = 0; m_sdl = 1'b0; m_mtl = 1'b0;
    end else begin
      nph  = m_ph;
      sdem = SD | m_sdl;
      mdem = MT | m_mtl;
      if (TICK) begin
        if (m_left > 0) m_left--;
        if (m_left == 0) begin
          case (m_ph)
            0: if (sdem || mdem) nph = 1;
            1: nph = 2;
            2: nph = 3;
            3: begin
              if (SD && m_ext < MAX_EXT) begin
                m_ext++;
                m_left = EXT_T;
              end else nph = 4;
            end
            4: nph = 5;
            5: nph = mdem ? 6 : 0;
            6: nph = 0;
            default: nph = 5;
          endcase
        end
      end
      if (SD && m_ph != 3) m_sdl = 1'b1;
      if (MT && m_ph != 6) m_mtl = 1'b1;
      if (nph != m_ph) begin
        m_left = dur(nph);
        if (nph == 3) begin m_sdl = 1'b0; m_ext = 0; end
        if (nph == 6) m_mtl = 1'b0;
      end
      m_ph = nph;
    end
    expq.push_back({3'(m_ph), lamps_of(m_ph)});
  end

  // Monitor: one expected entry per clock, compared away from the active edge.
  always @(negedge CLK) begin : monitor
    logic [9:0] e, a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {STATE, MR, MY, MG, MA, SR, SY, SG};
      n_cmp++;
      if (a !== e)
        begin
          n_bad++;
          $display("FAIL scoreboard t=%0t actual state=%0d lamps=%b required state=%0d lamps=%b",
                   $time, a[9:7], a[6:0], e[9:7], e[6:0]);
        end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input bit t, input bit s, input bit m, input bit r);
    @(negedge CLK);
    TICK = t; SD = s; MT = m; CLR_N = r;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic wait_state(input int s, input int budget, input string nm);
    int k = 0;
    while (int'(STATE) != s && k < budget) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      k++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk(nm, int'(STATE), s);
  endtask

  initial begin : driver
    int sg_ticks;
    // Reset and first tick out of all-red
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_state", int'(STATE), 5);
    chk("reset_mr_sr", int'({MR, SR, MG, SG}), 4'b1100);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_to_mg", int'(STATE), 0);

    // Long idle with no demand
    run_ticks(200);
    chk("idle_mg", int'({STATE, MG, SR}), 5'b00011);

    // Fresh MG, side pulse at tick 3
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    run_ticks(3);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    run_ticks(30);

    // Side detect held through SG: base plus three extensions
    wait_state(0, 100, "reach_mg_before_hold");
    sg_ticks = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (STATE == 3'd4) break;
      if (STATE == 3'd3) sg_ticks++;
      TICK = 1'b1; SD = 1'b1; MT = 1'b0; CLR_N = 1'b1;
    end
    chk("sd_hold_reached_sy", int'(STATE), 4);
    chk("sg_ext_ticks", sg_ticks, SG_T + MAX_EXT * EXT_T);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Turn demand: full side cycle then advance arrow
    wait_state(0, 100, "reach_mg_before_turn");
    step(1'b0, 1'b0, 1'b1, 1'b1);
    wait_state(6, 200, "reach_madv");
    chk("madv_lamps", int'({MR, MA, SR, MG, SG}), 5'b11100);
    run_ticks(40);
    chk("after_turn_mg", int'(STATE), 0);

    // Reset in the middle of side green with the timebase stopped
    step(1'b0, 1'b1, 1'b0, 1'b1);
    wait_state(3, 100, "reach_sg");
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_mid_sg", int'({STATE, SG}), 4'b1010);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("frozen_no_tick", int'(STATE), 5);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    run_ticks(20);
    chk("latches_cleared", int'(STATE), 0);

    // Randomized traffic with occasional resets
    repeat (3000)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 299) != 0);

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
